// File: rtl/i2c_scl_gen.sv
// I2C SCL timing generator: four programmable quarter-periods per SCL cycle,
// phase ticks for the master FSM, slave clock stretching with timeout.
module i2c_scl_gen #(
  parameter int CNT_W       = 16,
  parameter int DIV_MIN     = 2,
  parameter int STRETCH_MAX = 50000
) (
  input  logic             ref_clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] div_q,
  input  logic             stretch_en,
  input  logic             scl_in,
  output logic             scl_oe,
  output logic             low_mid_tick,
  output logic             rise_tick,
  output logic             high_mid_tick,
  output logic             fall_tick,
  output logic             busy,
  output logic             stretching,
  output logic             stretch_timeout
);

  localparam int SW = $clog2(STRETCH_MAX + 1);

  typedef enum logic [2:0] {IDLE, Q0, Q1, Q2, Q3} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_lat_q, div_lat_d;
  logic [SW-1:0]    str_cnt_q, str_cnt_d;
  logic [1:0]       sync_q, sync_d;
  logic             rose_q, rose_d;
  logic             scl_oe_q, scl_oe_d;
  logic             low_mid_q, low_mid_d;
  logic             rise_q, rise_d;
  logic             high_mid_q, high_mid_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;
  logic             stretching_q, stretching_d;
  logic             timeout_q, timeout_d;

  logic             scl_sync;
  logic             last;
  logic [CNT_W-1:0] div_clamped;

  assign scl_sync    = sync_q[1];
  assign last        = (cnt_q == div_lat_q - CNT_W'(1));
  assign div_clamped = (div_q < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : div_q;

  // Next-state, counters and registered outputs derived from the next state.
  // rose_q marks that the high half has started counting; Q2 with rose_q=0 is
  // the stretch wait, where cnt is held at 0.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_lat_d    = div_lat_q;
    str_cnt_d    = str_cnt_q;
    rose_d       = rose_q;
    sync_d       = {sync_q[0], scl_in};
    low_mid_d    = 1'b0;
    rise_d       = 1'b0;
    high_mid_d   = 1'b0;
    fall_d       = 1'b0;
    stretching_d = 1'b0;
    timeout_d    = timeout_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d   = Q0;
          div_lat_d = div_clamped;
          fall_d    = 1'b1;
          timeout_d = 1'b0;
        end
      end
      Q0: begin
        if (last) begin
          state_d   = Q1;
          cnt_d     = '0;
          low_mid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      Q1: begin
        if (last) begin
          state_d   = Q2;
          cnt_d     = '0;
          str_cnt_d = '0;
          if (!stretch_en || scl_sync) begin
            rise_d = 1'b1;
            rose_d = 1'b1;
          end else begin
            rose_d       = 1'b0;
            stretching_d = 1'b1;
            str_cnt_d    = SW'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      Q2: begin
        if (!rose_q) begin
          // Timeout is checked before scl_sync so it wins a same-cycle tie.
          if (str_cnt_q == SW'(STRETCH_MAX)) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            str_cnt_d = '0;
            cnt_d     = '0;
          end else if (stretch_en && !scl_sync) begin
            stretching_d = 1'b1;
            str_cnt_d    = str_cnt_q + SW'(1);
          end else begin
            rise_d    = 1'b1;
            rose_d    = 1'b1;
            str_cnt_d = '0;
          end
        end else if (last) begin
          state_d    = Q3;
          cnt_d      = '0;
          high_mid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      Q3: begin
        if (last) begin
          cnt_d = '0;
          if (enable) begin
            state_d   = Q0;
            div_lat_d = div_clamped;
            fall_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    scl_oe_d = (state_d == Q0) || (state_d == Q1);
    busy_d   = (state_d != IDLE);
  end

  // State, counters, synchroniser and output registers.
  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      div_lat_q    <= '0;
      str_cnt_q    <= '0;
      sync_q       <= '1;
      rose_q       <= 1'b0;
      scl_oe_q     <= 1'b0;
      low_mid_q    <= 1'b0;
      rise_q       <= 1'b0;
      high_mid_q   <= 1'b0;
      fall_q       <= 1'b0;
      busy_q       <= 1'b0;
      stretching_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_lat_q    <= div_lat_d;
      str_cnt_q    <= str_cnt_d;
      sync_q       <= sync_d;
      rose_q       <= rose_d;
      scl_oe_q     <= scl_oe_d;
      low_mid_q    <= low_mid_d;
      rise_q       <= rise_d;
      high_mid_q   <= high_mid_d;
      fall_q       <= fall_d;
      busy_q       <= busy_d;
      stretching_q <= stretching_d;
      timeout_q    <= timeout_d;
    end
  end

  assign scl_oe          = scl_oe_q;
  assign low_mid_tick    = low_mid_q;
  assign rise_tick       = rise_q;
  assign high_mid_tick   = high_mid_q;
  assign fall_tick       = fall_q;
  assign busy            = busy_q;
  assign stretching      = stretching_q;
  assign stretch_timeout = timeout_q;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Bench for i2c_scl_gen: wired-AND SCL bus with a stretching slave model,
// tick timelines predicted from period arithmetic (4*D + S per SCL period).
module tb_i2c_scl_gen;

  localparam int SMAX = 100;

  logic        ref_clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] div_q;
  logic        stretch_en;
  logic        scl_in;
  logic        scl_oe, low_mid_tick, rise_tick, high_mid_tick, fall_tick;
  logic        busy, stretching, stretch_timeout;

  logic slave_low = 1'b0;
  logic stuck     = 1'b0;

  // Open-drain bus: low if the master drives, the slave holds, or it is stuck.
  assign scl_in = ~scl_oe & ~slave_low & ~stuck;

  i2c_scl_gen #(.CNT_W(16), .DIV_MIN(2), .STRETCH_MAX(SMAX)) dut (
    .ref_clk(ref_clk), .reset_n(reset_n), .enable(enable), .div_q(div_q),
    .stretch_en(stretch_en), .scl_in(scl_in), .scl_oe(scl_oe),
    .low_mid_tick(low_mid_tick), .rise_tick(rise_tick),
    .high_mid_tick(high_mid_tick), .fall_tick(fall_tick), .busy(busy),
    .stretching(stretching), .stretch_timeout(stretch_timeout)
  );

  always #5 ref_clk = ~ref_clk;

  int cyc = 0;
  always @(posedge ref_clk) cyc <= cyc + 1;

  // Tick log (kind 0 fall, 1 low_mid, 2 rise, 3 high_mid) and cycle counters.
  int ev_k[$];
  int ev_t[$];
  int oe_cnt  = 0;
  int str_cyc = 0;
  always @(negedge ref_clk) begin
    if (fall_tick)     begin ev_k.push_back(0); ev_t.push_back(cyc); end
    if (low_mid_tick)  begin ev_k.push_back(1); ev_t.push_back(cyc); end
    if (rise_tick)     begin ev_k.push_back(2); ev_t.push_back(cyc); end
    if (high_mid_tick) begin ev_k.push_back(3); ev_t.push_back(cyc); end
    if (scl_oe)     oe_cnt++;
    if (stretching) str_cyc++;
  end

  // Slave: grabs SCL at mid-low, keeps it for hold_len cycles after the master releases.
  bit slave_on = 1'b0;
  int hold_len = 0;
  bit armed    = 1'b0;
  int c_entry  = -1;
  always @(negedge ref_clk) begin
    if (!slave_on) begin
      slave_low = 1'b0;
      armed     = 1'b0;
    end else begin
      if (low_mid_tick) begin slave_low = 1'b1; armed = 1'b1; c_entry = -1; end
      if (armed && !scl_oe && c_entry < 0) c_entry = cyc;
      if (armed && c_entry >= 0 && cyc >= c_entry + hold_len) begin
        slave_low = 1'b0;
        armed     = 1'b0;
      end
    end
  end

  int checks = 0;
  int passed = 0;

  task automatic step(input int n);
    repeat (n) begin @(negedge ref_clk); #1; end
  endtask

  task automatic clear_log();
    ev_k.delete(); ev_t.delete(); oe_cnt = 0; str_cyc = 0;
  endtask

  task automatic wait_kind(input int kind, input int nth, input int budget, output bit ok);
    int c;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      c = 0;
      foreach (ev_k[j]) if (ev_k[j] == kind) c++;
      if (c >= nth) begin ok = 1'b1; break; end
      step(1);
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok, output int t);
    ok = 1'b0; t = -1;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin ok = 1'b1; t = cyc; break; end
      step(1);
    end
  endtask

  task automatic test_reset();
    int bad;
    reset_n = 1'b0; enable = 1'b0; div_q = 16'd4; stretch_en = 1'b0;
    step(3);
    checks++;
    if ({scl_oe, low_mid_tick, rise_tick, high_mid_tick, fall_tick, busy, stretching, stretch_timeout} !== 8'b0)
      $display("FAIL reset_outputs: got %b expected 00000000",
        {scl_oe, low_mid_tick, rise_tick, high_mid_tick, fall_tick, busy, stretching, stretch_timeout});
    else passed++;
    reset_n = 1'b1;
    clear_log();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (scl_oe || busy) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL idle_quiet: got %0d active cycles expected 0", bad);
    else passed++;
    checks++;
    if (ev_k.size() !== 0) $display("FAIL idle_ticks: got %0d ticks expected 0", ev_k.size());
    else passed++;
  endtask

  // Runs n back-to-back periods, then drops enable in the last high half.
  task automatic test_periods(input int div, input bit sen, input bit son, input int h, input int n);
    int d, s, p, t0, t_idle, xk[$], xt[$];
    bit ok;
    d = (div < 2) ? 2 : div;
    s = !sen ? 0 : (son ? h + 3 : 3);
    p = 4 * d + s;
    div_q = 16'(div); stretch_en = sen; hold_len = h; slave_on = son;
    clear_log();
    t0 = cyc + 1;
    enable = 1'b1;
    wait_kind(3, n, n * p + 20, ok);
    checks++;
    if (!ok) $display("FAIL periods_high_mid_wait: got timeout expected %0d high_mid ticks", n);
    else passed++;
    enable = 1'b0;
    wait_idle(p + 20, ok, t_idle);
    checks++;
    if (t_idle !== t0 + n * p)
      $display("FAIL periods_idle_time div=%0d: got %0d expected %0d", div, t_idle, t0 + n * p);
    else passed++;
    for (int k = 0; k < n; k++) begin
      xk.push_back(0); xt.push_back(t0 + k * p);
      xk.push_back(1); xt.push_back(t0 + k * p + d);
      xk.push_back(2); xt.push_back(t0 + k * p + 2 * d + s);
      xk.push_back(3); xt.push_back(t0 + k * p + 3 * d + s);
    end
    step(2);
    slave_on = 1'b0;
    checks++;
    if (ev_k.size() !== xk.size()) $display("FAIL periods_tick_count: got %0d expected %0d", ev_k.size(), xk.size());
    else passed++;
    for (int i = 0; i < xk.size() && i < ev_k.size(); i++) begin
      checks++;
      if (ev_k[i] !== xk[i] || ev_t[i] !== xt[i])
        $display("FAIL periods_tick[%0d] div=%0d S=%0d: got kind %0d at %0d expected kind %0d at %0d",
                 i, div, s, ev_k[i], ev_t[i], xk[i], xt[i]);
      else passed++;
    end
    checks++;
    if (oe_cnt !== n * 2 * d) $display("FAIL periods_low_cycles: got %0d expected %0d", oe_cnt, n * 2 * d);
    else passed++;
    checks++;
    if (str_cyc !== n * s) $display("FAIL periods_stretch_cycles: got %0d expected %0d", str_cyc, n * s);
    else passed++;
    step(2);
  endtask

  task automatic test_div_change();
    int t0, t1, t_idle, xk[$], xt[$];
    bit ok;
    div_q = 16'd4; stretch_en = 1'b0;
    clear_log();
    t0 = cyc + 1;
    enable = 1'b1;
    wait_kind(1, 1, 40, ok);
    step(1);
    div_q = 16'd10;
    wait_kind(3, 2, 100, ok);
    checks++;
    if (!ok) $display("FAIL divchg_wait: got timeout expected second high_mid");
    else passed++;
    enable = 1'b0;
    wait_idle(60, ok, t_idle);
    t1 = t0 + 16;
    xk = '{0, 1, 2, 3, 0, 1, 2, 3};
    xt = '{t0, t0 + 4, t0 + 8, t0 + 12, t1, t1 + 10, t1 + 20, t1 + 30};
    checks++;
    if (t_idle !== t1 + 40) $display("FAIL divchg_idle_time: got %0d expected %0d", t_idle, t1 + 40);
    else passed++;
    checks++;
    if (ev_k.size() !== 8) $display("FAIL divchg_tick_count: got %0d expected 8", ev_k.size());
    else passed++;
    for (int i = 0; i < 8 && i < ev_k.size(); i++) begin
      checks++;
      if (ev_k[i] !== xk[i] || ev_t[i] !== xt[i])
        $display("FAIL divchg_tick[%0d]: got kind %0d at %0d expected kind %0d at %0d",
                 i, ev_k[i], ev_t[i], xk[i], xt[i]);
      else passed++;
    end
    step(2);
  endtask

  task automatic test_timeout();
    int d, t0, t_idle;
    bit ok;
    d = 3;
    div_q = 16'(d); stretch_en = 1'b1; stuck = 1'b1;
    clear_log();
    t0 = cyc + 1;
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    wait_idle(2 * d + SMAX + 20, ok, t_idle);
    checks++;
    if (t_idle !== t0 + 2 * d + SMAX) $display("FAIL timeout_time: got %0d expected %0d", t_idle, t0 + 2 * d + SMAX);
    else passed++;
    checks++;
    if (stretch_timeout !== 1'b1 || scl_oe !== 1'b0)
      $display("FAIL timeout_flag: got flag=%b oe=%b expected flag=1 oe=0", stretch_timeout, scl_oe);
    else passed++;
    checks++;
    if (str_cyc !== SMAX) $display("FAIL timeout_stretch_cycles: got %0d expected %0d", str_cyc, SMAX);
    else passed++;
    checks++;
    if (ev_k.size() !== 2 || ev_t[0] !== t0 || ev_t[1] !== t0 + d)
      $display("FAIL timeout_ticks: got %0d ticks expected fall at %0d and low_mid at %0d only", ev_k.size(), t0, t0 + d);
    else passed++;
    stuck = 1'b0;
    step(5);
    checks++;
    if (stretch_timeout !== 1'b1) $display("FAIL timeout_sticky: got %b expected 1", stretch_timeout);
    else passed++;
    enable = 1'b1;
    step(1);
    checks++;
    if (stretch_timeout !== 1'b0 || fall_tick !== 1'b1)
      $display("FAIL timeout_clear: got flag=%b fall=%b expected flag=0 fall=1", stretch_timeout, fall_tick);
    else passed++;
    enable = 1'b0;
    wait_idle(40, ok, t_idle);
    step(2);
  endtask

  task automatic test_enable_drop_and_reset();
    int t0, t_idle;
    bit ok;
    div_q = 16'd5; stretch_en = 1'b0;
    clear_log();
    t0 = cyc + 1;
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    wait_idle(60, ok, t_idle);
    checks++;
    if (t_idle !== t0 + 20) $display("FAIL drop_idle_time: got %0d expected %0d", t_idle, t0 + 20);
    else passed++;
    step(10);
    checks++;
    if (ev_k.size() !== 4 || ev_k[3] !== 3 || ev_t[3] !== t0 + 15)
      $display("FAIL drop_ticks: got %0d ticks expected 4 ending with high_mid at %0d", ev_k.size(), t0 + 15);
    else passed++;
    clear_log();
    enable = 1'b1;
    wait_kind(1, 1, 30, ok);
    step(1);
    checks++;
    if (scl_oe !== 1'b1 || busy !== 1'b1) $display("FAIL pre_reset_q1: got oe=%b busy=%b expected 1 1", scl_oe, busy);
    else passed++;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({scl_oe, low_mid_tick, rise_tick, high_mid_tick, fall_tick, busy, stretching, stretch_timeout} !== 8'b0)
      $display("FAIL async_reset: got %b expected 00000000",
        {scl_oe, low_mid_tick, rise_tick, high_mid_tick, fall_tick, busy, stretching, stretch_timeout});
    else passed++;
    enable = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(5);
    checks++;
    if (busy !== 1'b0 || scl_oe !== 1'b0) $display("FAIL post_reset_idle: got busy=%b oe=%b expected 0 0", busy, scl_oe);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_periods(125, 1'b0, 1'b0, 0, 2);
    test_periods(0, 1'b0, 1'b0, 0, 2);
    test_div_change();
    test_periods(4, 1'b1, 1'b1, 34, 2);
    test_periods(6, 1'b1, 1'b0, 0, 1);
    for (int i = 0; i < 8; i++)
      test_periods(int'($urandom_range(0, 12)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   int'($urandom_range(0, 40)), int'($urandom_range(1, 3)));
    test_timeout();
    test_enable_drop_and_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
